rca_wb_sequencer: RTL

Sits between the RCA unit and the RCA write ports of the register-file/writeback stage. Captures one completed RCA result set of up to NUM_RESULTS destination registers. Drains the set over NUM_WRITE_PORTS register-file write ports across one or more cycles, deferring writes that collide with the ALU's port-0 commit or with earlier same-rd entries. Once every write has issued, it releases the instruction ID through a done/id/ack handshake.

---
 rtl/rca_wb_sequencer_pkg.sv | 25 ++
 rtl/rca_wb_beat_select.sv | 75 +++++++
 rtl/rca_wb_sequencer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/rca_wb_sequencer_pkg.sv
// Shared types for the RCA writeback sequencer: sizing constants, instruction ID,
// FSM state and the captured result-set record.
package rca_wb_sequencer_pkg;

    localparam int unsigned NUM_RESULTS     = 4;
    localparam int unsigned NUM_WRITE_PORTS = 2;
    localparam int unsigned CNT_W           = $clog2(NUM_RESULTS + 1);
    localparam int unsigned ID_W            = 4;

    typedef logic [ID_W-1:0] id_t;

    typedef enum logic [1:0] {
        StIdle,
        StDrain,
        StRetire
    } rca_wb_state_t;

    typedef struct packed {
        id_t                          id;
        logic [CNT_W-1:0]             count;
        logic [NUM_RESULTS-1:0][4:0]  rd_addr;
        logic [NUM_RESULTS-1:0][31:0] data;
    } rca_result_set_t;

endpackage

// File: rtl/rca_wb_beat_select.sv
// Combinational beat builder: picks the next run of unblocked entries starting at ptr
// and binds slot k to write port k.
module rca_wb_beat_select #(
    parameter int unsigned NumResults    = 4,
    parameter int unsigned NumWritePorts = 2,
    localparam int unsigned CntW         = $clog2(NumResults + 1),
    localparam int unsigned IdxW         = (NumResults > 1) ? $clog2(NumResults) : 1
) (
    input  logic                               enable_i,
    input  logic [CntW-1:0]                    ptr_i,
    input  logic [CntW-1:0]                    count_i,
    input  logic [NumResults-1:0][4:0]         rd_addr_i,
    input  logic [NumResults-1:0][31:0]        data_i,
    input  logic                               alu_retired_i,
    input  logic [4:0]                         alu_rd_addr_i,
    output logic [NumWritePorts-1:0]           wp_valid_o,
    output logic [NumWritePorts-1:0][4:0]      wp_rd_addr_o,
    output logic [NumWritePorts-1:0][31:0]     wp_data_o,
    output logic [CntW-1:0]                    accepted_o,
    output logic                               blocked_o
);

    logic [NumWritePorts-1:0]       in_range;
    logic [NumWritePorts-1:0][4:0]  cand_rd;
    logic [NumWritePorts-1:0][31:0] cand_data;
    logic                           stop;
    logic                           hit;

    // Gather the candidate entries ptr..ptr+NumWritePorts-1 that lie below count
    always_comb begin
        in_range  = '0;
        cand_rd   = '0;
        cand_data = '0;
        for (int unsigned k = 0; k < NumWritePorts; k++) begin
            in_range[k]  = (32'(ptr_i) + 32'(k)) < 32'(count_i);
            cand_rd[k]   = rd_addr_i[IdxW'(32'(ptr_i) + 32'(k))];
            cand_data[k] = data_i[IdxW'(32'(ptr_i) + 32'(k))];
        end
    end

    // Accept slots in order until the first one colliding with the ALU or an earlier slot
    always_comb begin
        wp_valid_o   = '0;
        wp_rd_addr_o = '0;
        wp_data_o    = '0;
        accepted_o   = '0;
        blocked_o    = 1'b0;
        stop         = 1'b0;
        hit          = 1'b0;
        for (int unsigned k = 0; k < NumWritePorts; k++) begin
            hit = alu_retired_i && (alu_rd_addr_i != 5'd0) && (cand_rd[k] == alu_rd_addr_i);
            // Every slot before k is already accepted whenever slot k is reached
            for (int unsigned j = 0; j < k; j++) begin
                if ((cand_rd[k] != 5'd0) && (cand_rd[j] == cand_rd[k])) begin
                    hit = 1'b1;
                end
            end
            if (enable_i && in_range[k] && !stop) begin
                if (hit) begin
                    stop      = 1'b1;
                    blocked_o = 1'b1;
                end else begin
                    accepted_o = accepted_o + CntW'(1);
                    // rd 0 entries retire silently without a port strobe
                    if (cand_rd[k] != 5'd0) begin
                        wp_valid_o[k]   = 1'b1;
                        wp_rd_addr_o[k] = cand_rd[k];
                        wp_data_o[k]    = cand_data[k];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/rca_wb_sequencer.sv
// RCA writeback sequencer: captures one RCA result set, drains it over the RCA
// register-file write ports around ALU port-0 collisions, then retires its ID.
// Optional build macro RCA_WB_STATS_EN adds a saturating stall_count output.
module rca_wb_sequencer
    import rca_wb_sequencer_pkg::*;
(
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  rca_valid,
    output logic                                  rca_ready,
    input  id_t                                   rca_id,
    input  logic [CNT_W-1:0]                      rca_count,
    input  logic [NUM_RESULTS-1:0][4:0]           rca_rd_addr,
    input  logic [NUM_RESULTS-1:0][31:0]          rca_data,
    input  logic                                  alu_retired,
    input  logic [4:0]                            alu_rd_addr,
    output logic [NUM_WRITE_PORTS-1:0]            wp_valid,
    output logic [NUM_WRITE_PORTS-1:0][4:0]       wp_rd_addr,
    output logic [NUM_WRITE_PORTS-1:0][31:0]      wp_data,
    output logic                                  wb_done,
    output id_t                                   wb_id,
    input  logic                                  wb_ack,
    output logic                                  busy
`ifdef RCA_WB_STATS_EN
    ,
    output logic [31:0]                           stall_count
`endif
);

    rca_wb_state_t   state_q, state_d;
    rca_result_set_t set_q, set_d;
    logic [CNT_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] beat_accepted;
    logic [CNT_W-1:0] ptr_next;
    logic             beat_blocked;

    rca_wb_beat_select #(
        .NumResults    (NUM_RESULTS),
        .NumWritePorts (NUM_WRITE_PORTS)
    ) u_beat_select (
        .enable_i      (state_q == StDrain),
        .ptr_i         (ptr_q),
        .count_i       (set_q.count),
        .rd_addr_i     (set_q.rd_addr),
        .data_i        (set_q.data),
        .alu_retired_i (alu_retired),
        .alu_rd_addr_i (alu_rd_addr),
        .wp_valid_o    (wp_valid),
        .wp_rd_addr_o  (wp_rd_addr),
        .wp_data_o     (wp_data),
        .accepted_o    (beat_accepted),
        .blocked_o     (beat_blocked)
    );

    assign ptr_next = ptr_q + beat_accepted;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a stalled beat leaves ptr short of count and holds DRAIN
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (rca_valid) begin
                    state_d = (rca_count == '0) ? StRetire : StDrain;
                end
            end
            StDrain: begin
                if (ptr_next == set_q.count) begin
                    state_d = StRetire;
                end
            end
            StRetire: begin
                if (wb_ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Capture the set on acceptance and advance the drain pointer
    always_comb begin
        set_d = set_q;
        ptr_d = ptr_q;
        if (state_q == StIdle && rca_valid) begin
            set_d.id      = rca_id;
            set_d.count   = rca_count;
            set_d.rd_addr = rca_rd_addr;
            set_d.data    = rca_data;
            ptr_d         = '0;
        end else if (state_q == StDrain) begin
            ptr_d = ptr_next;
        end
    end

    // Held set and pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            set_q <= '0;
            ptr_q <= '0;
        end else begin
            set_q <= set_d;
            ptr_q <= ptr_d;
        end
    end

    // Handshake outputs decoded from the registered state
    always_comb begin
        rca_ready = (state_q == StIdle);
        wb_done   = (state_q == StRetire);
        wb_id     = set_q.id;
        busy      = (state_q != StIdle);
    end

`ifdef RCA_WB_STATS_EN
    logic [31:0] stall_count_q;

    // Count DRAIN cycles with any blocked candidate, saturating at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_q <= '0;
        end else if (state_q == StDrain && beat_blocked && stall_count_q != '1) begin
            stall_count_q <= stall_count_q + 32'd1;
        end
    end

    assign stall_count = stall_count_q;
`else
    logic unused_beat_blocked;
    assign unused_beat_blocked = beat_blocked;
`endif

endmodule
